// File: rtl/enigma_pkg.sv
// Shared letter types and helpers for the Enigma keypress/rotor path.
package enigma_pkg;

    localparam int unsigned LETTER_W    = 5;
    localparam int unsigned ROTOR_POS_W = 3 * LETTER_W;
    localparam int unsigned CNT_W       = 16;

    typedef logic [LETTER_W-1:0] letter_t;

    localparam letter_t LETTER_A = letter_t'(1);
    localparam letter_t LETTER_Z = letter_t'(26);

    // Packed start-position bundle, left rotor in the MSBs.
    typedef struct packed {
        letter_t l;
        letter_t m;
        letter_t r;
    } rotor_pos_t;

    function automatic letter_t letter_inc(input letter_t x);
        return (x == LETTER_Z) ? LETTER_A : letter_t'(x + letter_t'(1));
    endfunction

    function automatic logic letter_legal(input letter_t x);
        return (x >= LETTER_A) && (x <= LETTER_Z);
    endfunction

endpackage

// File: rtl/rotor_pos_ctr.sv
// One rotor position register: loads a start letter (illegal -> A) or steps with Z->A wrap.
module rotor_pos_ctr
    import enigma_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    input  logic                load,
    input  logic [LETTER_W-1:0] load_val,
    output logic [LETTER_W-1:0] pos
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= LETTER_A;
        end else if (load) begin
            pos <= letter_legal(load_val) ? load_val : LETTER_A;
        end else if (step) begin
            pos <= letter_inc(pos);
        end
    end

endmodule

// File: rtl/rotor_stepper.sv
// Keypress front end: steps three rotors (with middle double step) and registers letter + positions.
// Optional feature: define ROTOR_STEPPER_CNT_EN to add the saturating key_count output.
module rotor_stepper
    import enigma_pkg::*;
#(
    parameter letter_t NOTCH_R = letter_t'(17),
    parameter letter_t NOTCH_M = letter_t'(5)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [ROTOR_POS_W-1:0] load_pos,
    input  logic                   key_valid,
    input  logic [LETTER_W-1:0]    key_in,
    output logic                   key_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LETTER_W-1:0]    key_out,
    output logic [LETTER_W-1:0]    pos_l,
    output logic [LETTER_W-1:0]    pos_m,
    output logic [LETTER_W-1:0]    pos_r,
    output logic                   key_err
`ifdef ROTOR_STEPPER_CNT_EN
    ,
    output logic [CNT_W-1:0]       key_count
`endif
);

    rotor_pos_t start_pos;
    logic       accept;
    logic       key_ok;
    logic       step_r;
    logic       step_m;
    logic       step_l;

    assign start_pos = rotor_pos_t'(load_pos);

    // Single output register: a new key fits only when the slot is empty or draining.
    assign key_ready = !load && (!out_valid || out_ready);
    assign accept    = key_valid && key_ready;
    assign key_ok    = letter_legal(key_in);

    // Notch decode on pre-step positions; middle rotor at its notch carries itself too.
    always_comb begin
        step_r = 1'b0;
        step_m = 1'b0;
        step_l = 1'b0;
        if (accept && key_ok) begin
            step_r = 1'b1;
            step_m = (pos_r == NOTCH_R) || (pos_m == NOTCH_M);
            step_l = (pos_m == NOTCH_M);
        end
    end

    rotor_pos_ctr u_rotor_l (
        .clk      (clk),
        .rst      (rst),
        .step     (step_l),
        .load     (load),
        .load_val (start_pos.l),
        .pos      (pos_l)
    );

    rotor_pos_ctr u_rotor_m (
        .clk      (clk),
        .rst      (rst),
        .step     (step_m),
        .load     (load),
        .load_val (start_pos.m),
        .pos      (pos_m)
    );

    rotor_pos_ctr u_rotor_r (
        .clk      (clk),
        .rst      (rst),
        .step     (step_r),
        .load     (load),
        .load_val (start_pos.r),
        .pos      (pos_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            key_out   <= '0;
            key_err   <= 1'b0;
        end else begin
            key_err <= accept && !key_ok;
            if (load) begin
                out_valid <= 1'b0;
            end else if (accept && key_ok) begin
                out_valid <= 1'b1;
                key_out   <= key_in;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ROTOR_STEPPER_CNT_EN
    // Message-length counter for key-sheet checks; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            key_count <= '0;
        end else if (accept && key_ok && (key_count != {CNT_W{1'b1}})) begin
            key_count <= key_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rotor_stepper.sv
// Self-checking bench for rotor_stepper: directed table, hand sequences, random vs. reference model.
module tb_rotor_stepper;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [14:0] load_pos = '0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_in = '0;
    logic        key_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  key_out;
    logic [4:0]  pos_l, pos_m, pos_r;
    logic        key_err;
`ifdef ROTOR_STEPPER_CNT_EN
    logic [15:0] key_count;
`endif

    int errors = 0;
    int checks = 0;

    // Reference state
    int  m_l = 1, m_m = 1, m_r = 1, m_key = 0, m_cnt = 0;
    bit  m_valid = 0, m_err = 0;

    always #5 clk = ~clk;

    rotor_stepper dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_pos  (load_pos),
        .key_valid (key_valid),
        .key_in    (key_in),
        .key_ready (key_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .key_out   (key_out),
        .pos_l     (pos_l),
        .pos_m     (pos_m),
        .pos_r     (pos_r),
        .key_err   (key_err)
`ifdef ROTOR_STEPPER_CNT_EN
        ,
        .key_count (key_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wrap_inc(input int x);
        return (x % 26) + 1;
    endfunction

    function automatic int load_fix(input int x);
        return (x >= 1 && x <= 26) ? x : 1;
    endfunction

    // One clock: drive inputs, check key_ready, advance model, check registered outputs.
    task automatic apply(input bit r, input bit ld, input logic [14:0] lp,
                         input bit kv, input logic [4:0] k, input bit ordy);
        bit ready, acc, legal, sm, sl;
        rst = r; load = ld; load_pos = lp; key_valid = kv; key_in = k; out_ready = ordy;
        #1;
        ready = !ld && (!m_valid || ordy);
        if (!r) chk("key_ready", 32'(key_ready), 32'(ready));
        acc   = kv && ready;
        legal = (k >= 1) && (k <= 26);
        if (r) begin
            m_l = 1; m_m = 1; m_r = 1; m_key = 0; m_valid = 0; m_err = 0; m_cnt = 0;
        end else begin
            m_err = acc && !legal;
            if (ld) begin
                m_l = load_fix(int'(lp[14:10]));
                m_m = load_fix(int'(lp[9:5]));
                m_r = load_fix(int'(lp[4:0]));
                m_valid = 0;
                m_cnt = 0;
            end else if (acc && legal) begin
                sm = (m_r == 17) || (m_m == 5);
                sl = (m_m == 5);
                m_r = wrap_inc(m_r);
                if (sm) m_m = wrap_inc(m_m);
                if (sl) m_l = wrap_inc(m_l);
                m_key = int'(k);
                m_valid = 1;
                if (m_cnt < 65535) m_cnt++;
            end else if (m_valid && ordy) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("pos_l", 32'(pos_l), 32'(m_l));
        chk("pos_m", 32'(pos_m), 32'(m_m));
        chk("pos_r", 32'(pos_r), 32'(m_r));
        chk("key_out", 32'(key_out), 32'(m_key));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("key_err", 32'(key_err), 32'(m_err));
`ifdef ROTOR_STEPPER_CNT_EN
        chk("key_count", 32'(key_count), 32'(m_cnt));
`endif
    endtask

    typedef struct {
        bit          r;
        bit          ld;
        logic [14:0] lp;
        bit          kv;
        logic [4:0]  k;
        bit          ordy;
        int          el, em, er, ekey;
        bit          ev, ee;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [14:0] lpk(input int l, input int m, input int r);
        return {5'(l), 5'(m), 5'(r)};
    endfunction

    initial begin
        // Directed vectors with hand-derived expectations
        tbl[0]  = '{1, 0, 15'd0,            0, 5'd0,  1,  1,  1,  1, 0, 0, 0};
        tbl[1]  = '{0, 0, 15'd0,            1, 5'd4,  1,  1,  1,  2, 4, 1, 0};
        tbl[2]  = '{0, 1, lpk(1, 4, 16),    0, 5'd0,  1,  1,  4, 16, 4, 0, 0};
        tbl[3]  = '{0, 0, 15'd0,            1, 5'd1,  1,  1,  4, 17, 1, 1, 0};
        tbl[4]  = '{0, 0, 15'd0,            1, 5'd2,  1,  1,  5, 18, 2, 1, 0};
        tbl[5]  = '{0, 0, 15'd0,            1, 5'd3,  1,  2,  6, 19, 3, 1, 0};
        tbl[6]  = '{0, 1, lpk(26, 26, 26),  0, 5'd0,  1, 26, 26, 26, 3, 0, 0};
        tbl[7]  = '{0, 0, 15'd0,            1, 5'd5,  1, 26, 26,  1, 5, 1, 0};
        tbl[8]  = '{0, 0, 15'd0,            1, 5'd6,  1, 26, 26,  2, 6, 1, 0};
        tbl[9]  = '{0, 0, 15'd0,            0, 5'd0,  1, 26, 26,  2, 6, 0, 0};
        tbl[10] = '{0, 0, 15'd0,            1, 5'd0,  1, 26, 26,  2, 6, 0, 1};
        tbl[11] = '{0, 0, 15'd0,            1, 5'd27, 1, 26, 26,  2, 6, 0, 1};
        tbl[12] = '{0, 0, 15'd0,            0, 5'd0,  1, 26, 26,  2, 6, 0, 0};
        tbl[13] = '{0, 1, lpk(0, 27, 31),   0, 5'd0,  1,  1,  1,  1, 6, 0, 0};
        tbl[14] = '{0, 1, lpk(3, 0, 26),    0, 5'd0,  1,  3,  1, 26, 6, 0, 0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].r, tbl[i].ld, tbl[i].lp, tbl[i].kv, tbl[i].k, tbl[i].ordy);
            chk($sformatf("tbl%0d_l", i), 32'(pos_l), 32'(tbl[i].el));
            chk($sformatf("tbl%0d_m", i), 32'(pos_m), 32'(tbl[i].em));
            chk($sformatf("tbl%0d_r", i), 32'(pos_r), 32'(tbl[i].er));
            chk($sformatf("tbl%0d_key", i), 32'(key_out), 32'(tbl[i].ekey));
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_err", i), 32'(key_err), 32'(tbl[i].ee));
        end

        // Backpressure: second key held, positions frozen, then released
        apply(1, 0, 15'd0, 0, 5'd0, 0);
        apply(0, 0, 15'd0, 1, 5'd4, 0);
        chk("bp_first_r", 32'(pos_r), 32'd2);
        key_valid = 1'b1; key_in = 5'd7; out_ready = 1'b0;
        #1;
        chk("bp_ready_low", 32'(key_ready), 32'd0);
        apply(0, 0, 15'd0, 1, 5'd7, 0);
        chk("bp_frozen_r", 32'(pos_r), 32'd2);
        chk("bp_held_key", 32'(key_out), 32'd4);
        chk("bp_held_valid", 32'(out_valid), 32'd1);
        apply(0, 0, 15'd0, 1, 5'd7, 1);
        chk("bp_release_r", 32'(pos_r), 32'd3);
        chk("bp_release_key", 32'(key_out), 32'd7);
        apply(0, 0, 15'd0, 0, 5'd0, 1);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Reset wins over load and key in the same cycle
        apply(0, 0, 15'd0, 1, 5'd9, 1);
        apply(1, 1, lpk(5, 6, 7), 1, 5'd9, 1);
        chk("rst_ovr_l", 32'(pos_l), 32'd1);
        chk("rst_ovr_m", 32'(pos_m), 32'd1);
        chk("rst_ovr_r", 32'(pos_r), 32'd1);
        chk("rst_ovr_key", 32'(key_out), 32'd0);
        chk("rst_ovr_valid", 32'(out_valid), 32'd0);
        chk("rst_ovr_err", 32'(key_err), 32'd0);

`ifdef ROTOR_STEPPER_CNT_EN
        apply(0, 0, 15'd0, 1, 5'd1, 1);
        apply(0, 0, 15'd0, 1, 5'd2, 1);
        apply(0, 0, 15'd0, 1, 5'd3, 1);
        chk("cnt_three", 32'(key_count), 32'd3);
        apply(0, 1, lpk(1, 1, 1), 0, 5'd0, 1);
        chk("cnt_load_clr", 32'(key_count), 32'd0);
`endif

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            bit r, ld, kv, ordy;
            logic [4:0] k;
            r    = ($urandom_range(0, 59) == 0);
            ld   = ($urandom_range(0, 11) == 0);
            kv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 3) != 0);
            if ((m_valid && ordy) || $urandom_range(0, 4) != 0)
                k = 5'($urandom_range(1, 26));
            else
                k = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(27, 31));
            apply(r, ld, 15'($urandom), kv, k, ordy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
